// File: rtl/ev22_uinst_issue.sv
// EV22 microinstruction issue stage: picks a decoder output, holds it, and issues it under
// valid/ready. A bus-C scoreboard catches read-after-write hazards and inserts NOP bubbles.
module ev22_uinst_issue #(
  parameter int unsigned PipeDepth = 3,
  parameter logic [33:0] NopUi     = 34'h0,
  parameter int unsigned CntW      = 16,
  // Bus field geometry inside the 34-bit microinstruction
  parameter int unsigned BusW      = 5,
  parameter int unsigned BusALsb   = 10,
  parameter int unsigned BusBLsb   = 5,
  parameter int unsigned BusCLsb   = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [19:0]     inst_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [33:0]     ui_1_i,
  input  logic [33:0]     ui_2_i,
  input  logic [33:0]     ui_3_i,
  input  logic [33:0]     ui_4_i,
  input  logic            flush_i,
  output logic [33:0]     microinst_o,
  output logic            ui_valid_o,
  input  logic            ui_ready_i,
  output logic            bubble_o,
  output logic [CntW-1:0] bubble_cnt_o
);

  logic [33:0]                      hold_q, hold_d, out_q, out_d, sel;
  logic                             hold_v_q, hold_v_d, ui_valid_q, ui_valid_d;
  logic                             bubble_q, bubble_d;
  logic [PipeDepth-1:0][BusW-1:0]   sb_q, sb_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic [BusW-1:0]                  src_a, src_b, out_c;
  logic                             haz, slot_free, hold_moves, accept;

  function automatic logic hit(input logic [BusW-1:0] a, input logic [BusW-1:0] b,
                               input logic [BusW-1:0] dst);
    return (dst != '0) && (((a != '0) && (a == dst)) || ((b != '0) && (b == dst)));
  endfunction

  // First nonzero opcode nybble from the top selects the decoder.
  always_comb begin
    if (inst_i[19:16] != 4'h0)      sel = ui_1_i;
    else if (inst_i[15:12] != 4'h0) sel = ui_2_i;
    else if (inst_i[11:8] != 4'h0)  sel = ui_3_i;
    else if (inst_i[7:4] != 4'h0)   sel = ui_4_i;
    else                            sel = NopUi;
  end

  assign src_a = hold_q[BusALsb +: BusW];
  assign src_b = hold_q[BusBLsb +: BusW];
  assign out_c = out_q[BusCLsb +: BusW];

  always_comb begin
    haz = ui_valid_q && hit(src_a, src_b, out_c);
    for (int i = 0; i < int'(PipeDepth); i++) begin
      haz = haz | hit(src_a, src_b, sb_q[i]);
    end
  end

  assign slot_free    = !ui_valid_q || ui_ready_i;
  assign hold_moves   = slot_free && hold_v_q && !haz;
  assign inst_ready_o = !flush_i && (!hold_v_q || hold_moves);
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    out_d      = out_q;
    ui_valid_d = ui_valid_q;
    bubble_d   = bubble_q;
    sb_d       = sb_q;
    cnt_d      = cnt_q;

    // Scoreboard tracks datapath progress, so it shifts even across a flush.
    if (ui_ready_i) begin
      for (int i = 1; i < int'(PipeDepth); i++) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0] = (ui_valid_q && !bubble_q) ? out_c : '0;
    end

    if (ui_valid_q && ui_ready_i && bubble_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush_i) begin
      hold_v_d   = 1'b0;
      ui_valid_d = 1'b0;
      bubble_d   = 1'b0;
    end else begin
      if (slot_free) begin
        if (hold_v_q && !haz) begin
          out_d      = hold_q;
          bubble_d   = 1'b0;
          ui_valid_d = 1'b1;
        end else if (hold_v_q) begin
          out_d      = NopUi;
          bubble_d   = 1'b1;
          ui_valid_d = 1'b1;
        end else begin
          ui_valid_d = 1'b0;
          bubble_d   = 1'b0;
        end
      end
      if (accept) begin
        hold_d   = sel;
        hold_v_d = 1'b1;
      end else if (hold_moves) begin
        hold_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q     <= NopUi;
      hold_v_q   <= 1'b0;
      out_q      <= NopUi;
      ui_valid_q <= 1'b0;
      bubble_q   <= 1'b0;
      sb_q       <= '0;
      cnt_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      out_q      <= out_d;
      ui_valid_q <= ui_valid_d;
      bubble_q   <= bubble_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
    end
  end

  assign microinst_o  = out_q;
  assign ui_valid_o   = ui_valid_q;
  assign bubble_o     = bubble_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ev22_uinst_issue.sv
// Directed bench for ev22_uinst_issue; a second instance with a 4-bit counter shares the
// stimulus so counter saturation is observed alongside the full-width count.
module tb_ev22_uinst_issue;

  logic        clk, rst;
  logic [19:0] inst;
  logic        inst_valid, flush, ui_ready;
  logic [33:0] ui_1, ui_2, ui_3, ui_4;
  logic        inst_ready, ui_valid, bubble;
  logic [33:0] microinst;
  logic [15:0] bubble_cnt;
  logic        inst_ready4, ui_valid4, bubble4;
  logic [33:0] microinst4;
  logic [3:0]  bubble_cnt4;
  int          total = 0;
  int          bad = 0;

  localparam logic [33:0] Nop = 34'h0;

  ev22_uinst_issue dut (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(inst_valid),
    .inst_ready_o(inst_ready), .ui_1_i(ui_1), .ui_2_i(ui_2), .ui_3_i(ui_3), .ui_4_i(ui_4),
    .flush_i(flush), .microinst_o(microinst), .ui_valid_o(ui_valid), .ui_ready_i(ui_ready),
    .bubble_o(bubble), .bubble_cnt_o(bubble_cnt)
  );

  ev22_uinst_issue #(.CntW(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(inst_valid),
    .inst_ready_o(inst_ready4), .ui_1_i(ui_1), .ui_2_i(ui_2), .ui_3_i(ui_3), .ui_4_i(ui_4),
    .flush_i(flush), .microinst_o(microinst4), .ui_valid_o(ui_valid4), .ui_ready_i(ui_ready),
    .bubble_o(bubble4), .bubble_cnt_o(bubble_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tag in the top bits, then busA, busB, busC (5 bits each)
  function automatic logic [33:0] mk(input int tag, input int a, input int b, input int c);
    logic [18:0] t;
    logic [4:0]  fa, fb, fc;
    t = 19'(tag); fa = 5'(a); fb = 5'(b); fc = 5'(c);
    return {t, fa, fb, fc};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer (busC=5) on UI_1 followed by a consumer (busA=5) on UI_2.
  task automatic raw_pair(input logic [33:0] prod, input logic [33:0] cons,
                          input int cnt_exp, input int cnt4_exp);
    ui_1 = prod; ui_2 = cons;
    inst = 20'h10000; inst_valid = 1'b1;
    tick();
    inst = 20'h01000;
    tick();
    inst_valid = 1'b0;
    chk("raw_prod", microinst, prod);
    chk("raw_prod_bubble", 34'(bubble), 34'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("raw_bubble", 34'(bubble), 34'd1);
      chk("raw_bubble_nop", microinst, Nop);
      chk("raw_bubble_valid", 34'(ui_valid), 34'd1);
      chk("raw_ready", 34'(inst_ready), (i == 3) ? 34'd1 : 34'd0);
    end
    tick();
    chk("raw_cons", microinst, cons);
    chk("raw_cons_bubble", 34'(bubble), 34'd0);
    chk("raw_cnt", 34'(bubble_cnt), 34'(cnt_exp));
    chk("raw_cnt4", 34'(bubble_cnt4), 34'(cnt4_exp));
    tick();
    chk("raw_idle", 34'(ui_valid), 34'd0);
  endtask

  initial begin
    rst = 1'b1; inst = '0; inst_valid = 1'b0; flush = 1'b0; ui_ready = 1'b1;
    ui_1 = '0; ui_2 = '0; ui_3 = '0; ui_4 = '0;
    #3;
    chk("rst_valid", 34'(ui_valid), 34'd0);
    chk("rst_uinst", microinst, Nop);
    chk("rst_bubble", 34'(bubble), 34'd0);
    chk("rst_cnt", 34'(bubble_cnt), 34'd0);
    chk("rst_ready", 34'(inst_ready), 34'd1);
    #9 rst = 1'b0;
    tick();

    // Decoder select
    ui_1 = mk(1, 0, 0, 0); ui_2 = mk(2, 0, 0, 0); ui_3 = mk(3, 0, 0, 0); ui_4 = mk(4, 0, 0, 0);
    inst = 20'h00030; inst_valid = 1'b1;
    chk("dec_ready", 34'(inst_ready), 34'd1);
    tick();
    chk("dec_latency", 34'(ui_valid), 34'd0);
    inst = 20'h01200;
    tick();
    chk("dec_ui4", microinst, mk(4, 0, 0, 0));
    chk("dec_ui4_valid", 34'(ui_valid), 34'd1);
    inst = 20'h00000;
    tick();
    chk("dec_ui2", microinst, mk(2, 0, 0, 0));
    chk("dec_ui2_bubble", 34'(bubble), 34'd0);
    inst_valid = 1'b0;
    tick();
    chk("dec_nop", microinst, Nop);
    chk("dec_nop_valid", 34'(ui_valid), 34'd1);
    chk("dec_nop_bubble", 34'(bubble), 34'd0);
    tick();
    chk("dec_idle", 34'(ui_valid), 34'd0);
    chk("dec_cnt", 34'(bubble_cnt), 34'd0);

    // RAW hazard: PipeDepth+1 = 4 bubbles
    raw_pair(mk(5, 0, 0, 5), mk(6, 5, 0, 0), 4, 4);

    // Back-pressure
    ui_3 = mk(7, 0, 0, 0); ui_4 = mk(8, 0, 0, 0);
    ui_ready = 1'b0;
    inst = 20'h00100; inst_valid = 1'b1;
    tick();
    inst = 20'h00010;
    tick();
    inst_valid = 1'b0;
    chk("bp_first", microinst, mk(7, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 34'(inst_ready), 34'd0);
      tick();
      chk("bp_stable", microinst, mk(7, 0, 0, 0));
      chk("bp_valid", 34'(ui_valid), 34'd1);
    end
    ui_ready = 1'b1;
    tick();
    chk("bp_second", microinst, mk(8, 0, 0, 0));
    tick();
    chk("bp_drain", 34'(ui_valid), 34'd0);

    // Flush: held X is dropped, consumer still sees P's destination in the scoreboard
    ui_1 = mk(9, 0, 0, 3); ui_2 = mk(11, 0, 3, 0); ui_3 = mk(10, 0, 0, 0);
    inst = 20'h10000; inst_valid = 1'b1;
    tick();
    inst = 20'h00100;
    tick();
    chk("fl_prod", microinst, mk(9, 0, 0, 3));
    inst_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_ready", 34'(inst_ready), 34'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 34'(ui_valid), 34'd0);
    chk("fl_bubble", 34'(bubble), 34'd0);
    inst = 20'h01000; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("fl_no_x", 34'(ui_valid), 34'd0);
    tick();
    chk("fl_sb_bubble1", 34'(bubble), 34'd1);
    tick();
    chk("fl_sb_bubble2", 34'(bubble), 34'd1);
    tick();
    chk("fl_cons", microinst, mk(11, 0, 3, 0));
    chk("fl_cnt", 34'(bubble_cnt), 34'd6);
    tick();

    // Saturation of the 4-bit counter
    raw_pair(mk(12, 0, 0, 5), mk(13, 0, 5, 0), 10, 10);
    raw_pair(mk(14, 0, 0, 7), mk(15, 7, 0, 0), 14, 14);
    raw_pair(mk(16, 0, 0, 5), mk(17, 5, 0, 0), 18, 15);
    raw_pair(mk(18, 0, 0, 9), mk(19, 9, 9, 0), 22, 15);

    // Asynchronous reset mid-stream
    ui_1 = mk(20, 0, 0, 0); ui_2 = mk(21, 0, 0, 0);
    inst = 20'h10000; inst_valid = 1'b1;
    tick();
    inst = 20'h01000;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 34'(ui_valid), 34'd0);
    chk("arst_uinst", microinst, Nop);
    chk("arst_ready", 34'(inst_ready), 34'd1);
    chk("arst_cnt", 34'(bubble_cnt), 34'd0);
    chk("arst_cnt4", 34'(bubble_cnt4), 34'd0);
    inst_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("arst_no_issue1", 34'(ui_valid), 34'd0);
    tick();
    chk("arst_no_issue2", 34'(ui_valid), 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ev22_uinst_issue.md
Name: ev22_uinst_issue

Overview:
- Microinstruction issue controller for the EV22 multi-stage processor.
- Accepts a 20-bit instruction and selects the matching microinstruction from the four opcode-nybble decoders (MIR_1..MIR_4, 34-bit outputs).
- Registers the selected microinstruction and issues it to the datapath under a valid/ready handshake.
- Inserts NOP bubbles on read-after-write hazards, tracked by a bus-C destination scoreboard.

Parameters:
- PIPE_DEPTH, 3, number of datapath stages after issue in which a bus-C write is still pending (1..8).
- NOP_UI, NOP_u, 34-bit microinstruction issued as a bubble.
- CNT_W, 16, width of the bubble statistics counter.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- INST  in  20  instruction from fetch; also drives the MIR_1..MIR_4 decoders.
- INST_VALID  in  1  INST is valid.
- INST_READY  out  1  controller accepts INST this cycle.
- UI_1, UI_2, UI_3, UI_4  in  34 each  decoder outputs for the first, second, third and fourth opcode nybble.
- FLUSH  in  1  synchronous discard of held/issued work (branch redirect).
- MICROINST  out  34  issued microinstruction.
- UI_VALID  out  1  MICROINST is valid.
- UI_READY  in  1  datapath advances this cycle.
- BUBBLE  out  1  current MICROINST is an inserted bubble.
- BUBBLE_CNT  out  CNT_W  saturating count of bubbles transferred.

Behaviour:
- Clock/reset: one clock (CLK); reset (RESET) is asynchronous and active-high.
- Reset values: HOLD_V=0, UI_VALID=0, MICROINST=NOP_UI, BUBBLE=0, all scoreboard entries=0, BUBBLE_CNT=0.
- Fields: busA, busB and busC are taken at the uINST_LIST.vh field positions (iBUSA_*, iBUSB_*, iBUSC_*).
  - busC=0 means no write.
  - busA/busB=0 means no read and is never checked.
- Decoder select, applied when INST is accepted; the first nonzero nybble scanning from the top wins:
  - INST[19:16]≠0 → UI_1.
  - else INST[15:12]≠0 → UI_2.
  - else INST[11:8]≠0 → UI_3.
  - else INST[7:4]≠0 → UI_4.
  - all four zero → NOP_UI.
- Hold register:
  - Accept when INST_VALID & INST_READY; the selected microinstruction goes to HOLD and HOLD_V is set.
  - INST_READY = !HOLD_V | HOLD_MOVES (combinational).
- Output slot is free when !UI_VALID | UI_READY.
- HAZ is true when HOLD's nonzero busA or busB equals any nonzero destination in:
  - OUT, if UI_VALID, or
  - any scoreboard entry SB[0..PIPE_DEPTH-1].
- Each cycle the output slot is free:
  - HOLD_V & !HAZ → OUT<=HOLD, BUBBLE<=0, UI_VALID<=1; this is HOLD_MOVES.
  - HOLD_V & HAZ → OUT<=NOP_UI, BUBBLE<=1, UI_VALID<=1.
  - !HOLD_V → UI_VALID<=0, BUBBLE<=0.
- Scoreboard:
  - Shifts only on cycles with UI_READY=1.
  - SB[0] <= busC of OUT if UI_VALID & !BUBBLE, else 0; SB[i] <= SB[i-1].
  - UI_READY=0 freezes SB, OUT and HOLD.
- Latency: INST accepted at edge k → MICROINST valid after edge k+1, if no hazard and the slot is free.
- Throughput: 1 microinstruction/cycle for independent instructions.
- Dependent back-to-back pair with UI_READY=1: exactly PIPE_DEPTH+1 bubbles between producer and consumer.
- BUBBLE_CNT increments on UI_VALID & UI_READY & BUBBLE and saturates at all-ones.
- FLUSH (priority over everything except RESET): next edge sets HOLD_V=0, UI_VALID=0, BUBBLE=0.
  - INST_READY=0 during the FLUSH cycle.
  - Scoreboard is kept, because in-flight datapath writes still complete.
  - BUBBLE_CNT is kept.
- Simultaneous accept and move: the new INST enters HOLD on the same edge the old HOLD moves to OUT.
- RESET asserted mid-operation clears all state immediately; no partial issue after release.

Test Plan:
- Reset:
  - Stimulus: assert RESET asynchronously mid-stream.
  - Response: UI_VALID=0, MICROINST=NOP_UI, INST_READY=1 and BUBBLE_CNT=0 before the next CLK edge.
- Decoder select:
  - Stimulus: INST=20'h00030, then 20'h01200, then 20'h00000, with distinct UI_n patterns.
  - Response: MICROINST = UI_4, then UI_2, then NOP_UI; each appears one cycle after accept; no bubbles.
- RAW hazard:
  - Stimulus: PIPE_DEPTH=3; producer busC=5, then consumer busA=5; UI_READY=1.
  - Response: exactly 4 bubbles (BUBBLE=1) and BUBBLE_CNT=4; consumer issued 5 cycles after producer.
- Back-pressure:
  - Stimulus: hold UI_READY=0 for 6 cycles with 2 instructions pending.
  - Response: MICROINST stable and INST_READY=0 after HOLD fills; SB unchanged; order preserved on release.
- Flush:
  - Stimulus: FLUSH while HOLD_V=1 and UI_VALID=1.
  - Response: next cycle UI_VALID=0 and the held instruction is never issued; a subsequent dependent instruction still bubbles against SB.
- Saturation:
  - Stimulus: CNT_W=4; force 20 bubbles.
  - Response: BUBBLE_CNT=15 and it holds there.
